// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered or first-word-fall-through read.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(AFULL_TH));
  assign almost_empty = (r_count <= CW'(AEMPTY_TH));
  assign count        = r_count;

  assign w_wr_ok = wr_en && !full;
  assign w_rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left unreset; only gated off during reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_ok)
      r_mem[r_wptr[AW-1:0]] <= data_in;
  end

  // The wrap bits make the pointer distance equal the occupancy.
  always_ff @(posedge clk) begin
    if (rst_n)
      assert (r_count == (r_wptr - r_rptr));
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : r_mem[r_rptr[AW-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (!rst_n)
          r_dout <= '0;
        else if (w_rd_ok)
          r_dout <= r_mem[r_rptr[AW-1:0]];
      end
      assign data_out = r_dout;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (wr_en && full)  r_ovf <= 1'b1;
      if (rd_en && empty) r_unf <= 1'b1;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: queue-model bench driving a registered and an FWFT
// sync_fifo with shared directed and random stimulus.
module tb_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_in;

  logic [W-1:0]  dout0, dout1;
  logic          full0, empty0, af0, ae0;
  logic          full1, empty1, af1, ae1;
  logic [CW-1:0] count0, count1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf0, unf0, ovf1, unf1;
`endif

  always #5 clk = ~clk;

  sync_fifo #(.FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout0),
    .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0),
    .count(count0)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(ovf0), .underflow(unf0)
`endif
  );

  sync_fifo #(.FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout1),
    .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1),
    .count(count1)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(ovf1), .underflow(unf1)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus the registered output.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  bit           m_ovf, m_unf;
  bit           m_f, m_e;
  bit           run = 1'b0;
  int           n;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_f = (q.size() == D);
      m_e = (q.size() == 0);
      if (wr_en && m_f) m_ovf = 1'b1;
      if (rd_en && m_e) m_unf = 1'b1;
      if (rd_en && !m_e) m_dout = q.pop_front();
      if (wr_en && !m_f) q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (run) begin
      n = q.size();
      chk("count0", 32'(count0), n);
      chk("count1", 32'(count1), n);
      chk("flags0", {full0, empty0, af0, ae0},
          {n == D, n == 0, n >= D - 2, n <= 2});
      chk("flags1", {full1, empty1, af1, ae1},
          {n == D, n == 0, n >= D - 2, n <= 2});
      chk("dout0", 32'(dout0), 32'(m_dout));
      if (n > 0) chk("dout1", 32'(dout1), 32'(q[0]));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("err0", {ovf0, unf0}, {m_ovf, m_unf});
      chk("err1", {ovf1, unf1}, {m_ovf, m_unf});
`endif
    end
  end

  task automatic cyc(bit w, logic [W-1:0] d, bit r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  int wp, rp;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0;
    rd_en = 1'b0; data_in = '0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    run = 1'b1;
    chk("rst_count", 32'(count0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_ae", 32'(ae0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_af", 32'(af0), 0);
    chk("rst_dout", 32'(dout0), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) cyc(1, W'(i + 1), 0);
    chk("fill_count", 32'(count0), 16);
    chk("fill_full", 32'(full0), 1);
    cyc(1, 8'hFF, 0);
    chk("ovf_count", 32'(count0), 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1);
      chk("rd_order", 32'(dout0), i + 1);
    end
    chk("drain_empty", 32'(empty0), 1);

    for (int i = 0; i < 16; i++) begin
      cyc(1, W'(8'h20 + i), 0);
      chk("ae_edge", 32'(ae0), 32'((i + 1) <= 2));
      chk("af_edge", 32'(af0), 32'((i + 1) >= 14));
    end

    cyc(1, 8'h77, 1);
    chk("full_rw_count", 32'(count0), 15);
    chk("full_rw_dout", 32'(dout0), 32'h20);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1);
    cyc(1, 8'h55, 1);
    chk("empty_rw_count", 32'(count0), 1);
    chk("empty_rw_dout", 32'(dout0), 32'h2F);

    for (int i = 0; i < 14; i++) cyc(1, W'(8'h60 + i), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, W'(8'h80 + i), 1);
      if (i == 0) chk("wrap_first", 32'(dout0), 32'h55);
      if (i == 1) chk("wrap_second", 32'(dout0), 32'h60);
    end
    chk("wrap_count", 32'(count0), 15);

    rst_n = 1'b0;
    cyc(0, 0, 0);
    rst_n = 1'b1;
    cyc(1, 8'hA5, 0);
    chk("fwft_dout", 32'(dout1), 32'hA5);
    chk("fwft_nempty", 32'(empty1), 0);
    cyc(0, 0, 1);
    chk("fwft_empty", 32'(empty1), 1);

    cyc(0, 0, 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("unf_set", 32'(unf0), 1);
`endif
    for (int i = 0; i < 9; i++) cyc(1, W'(8'hC0 + i), 0);
    cyc(0, 0, 1);
    cyc(1, 8'hD0, 0);
    chk("burst_count", 32'(count0), 9);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("unf_hold", 32'(unf0), 1);
`endif
    rst_n = 1'b0;
    cyc(1, 8'h11, 1);
    chk("mid_rst_count", 32'(count0), 0);
    chk("mid_rst_empty", 32'(empty0), 1);
    chk("mid_rst_dout", 32'(dout0), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("unf_clr", 32'(unf0), 0);
`endif
    rst_n = 1'b1;

    wp = 50;
    rp = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        wp = $urandom_range(10, 90);
        rp = $urandom_range(10, 90);
      end
      rst_n = ($urandom_range(0, 499) != 0);
      cyc($urandom_range(0, 99) < wp, W'($urandom),
          $urandom_range(0, 99) < rp);
    end
    rst_n = 1'b1;
    cyc(0, 0, 0);
    run = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
